// File: rtl/led_pkg.sv
// Shared types and defaults for the LED code player.
package led_pkg;

    // Playback phases of the LED serialiser.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ON      = 2'd1,
        BITGAP  = 2'd2,
        CODEGAP = 2'd3
    } state_t;

    // Default phase lengths in time units.
    localparam int DEF_SHORT_U   = 1;
    localparam int DEF_LONG_U    = 3;
    localparam int DEF_BITGAP_U  = 1;
    localparam int DEF_CODEGAP_U = 3;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_unit_tick.sv
// Time-unit prescaler: pulses tick once every TICK_DIV cycles after clr.
module led_unit_tick
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int PW = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    // Tick on the last cycle of each unit; the owner samples it on the next edge.
    assign tick = (cnt == LAST);

    // Free-running divider, restarted by clr so every phase begins at a unit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_code_player.sv
// Plays NUM_CODES latched codes on one LED, MSB first: long flash for 1, short for 0.
module led_code_player
    import led_pkg::*;
#(
    parameter int CODE_W    = 5,
    parameter int NUM_CODES = 4,
    parameter int TICK_DIV  = 25_000_000,
    parameter int SHORT_U   = DEF_SHORT_U,
    parameter int LONG_U    = DEF_LONG_U,
    parameter int BITGAP_U  = DEF_BITGAP_U,
    parameter int CODEGAP_U = DEF_CODEGAP_U
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                repeat_en,
    input  logic [NUM_CODES*CODE_W-1:0]         codes,
    output logic                                led,
    output logic                                busy,
    output logic                                done,
    output logic [clog2_min1(NUM_CODES)-1:0]    cur_code,
    output logic [clog2_min1(CODE_W)-1:0]       cur_bit
);

    localparam int CCW   = clog2_min1(NUM_CODES);
    localparam int CBW   = clog2_min1(CODE_W);
    localparam int MAX_U = (LONG_U > CODEGAP_U) ? LONG_U : CODEGAP_U;
    localparam int UW    = clog2_min1(MAX_U + 1);
    localparam logic [CCW-1:0] LAST_CODE = CCW'(NUM_CODES - 1);
    localparam logic [CBW-1:0] TOP_BIT   = CBW'(CODE_W - 1);

    state_t            state;
    logic [CODE_W-1:0] code_mem [NUM_CODES];
    logic [UW-1:0]     unit_cnt;
    logic [UW-1:0]     unit_last;
    logic              tick;
    logic              clr;
    logic              phase_done;
    logic              bit_val;

    led_unit_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    assign bit_val    = code_mem[cur_code][cur_bit];
    assign phase_done = tick && (unit_cnt == unit_last);
    // Prescaler and unit count restart at every phase boundary, so no drift accumulates.
    assign clr        = (state == IDLE) || abort || phase_done;

    // Last unit index of the phase currently being timed.
    always_comb begin
        unit_last = '0;
        case (state)
            ON:      unit_last = bit_val ? UW'(LONG_U - 1) : UW'(SHORT_U - 1);
            BITGAP:  unit_last = UW'(BITGAP_U - 1);
            CODEGAP: unit_last = UW'(CODEGAP_U - 1);
            default: unit_last = '0;
        endcase
    end

    // Units elapsed within the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_cnt <= '0;
        end else if (clr) begin
            unit_cnt <= '0;
        end else if (tick) begin
            unit_cnt <= unit_cnt + 1'b1;
        end
    end

    // Playback sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            led      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_code <= '0;
            cur_bit  <= TOP_BIT;
            for (int i = 0; i < NUM_CODES; i++) begin
                code_mem[i] <= '0;
            end
        end else if (abort) begin
            state    <= IDLE;
            led      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_code <= '0;
            cur_bit  <= TOP_BIT;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CODES; i++) begin
                            code_mem[i] <= codes[i*CODE_W +: CODE_W];
                        end
                        state    <= ON;
                        led      <= 1'b1;
                        busy     <= 1'b1;
                        cur_code <= '0;
                        cur_bit  <= TOP_BIT;
                    end
                end
                ON: begin
                    if (phase_done) begin
                        led   <= 1'b0;
                        state <= (cur_bit == '0) ? CODEGAP : BITGAP;
                    end
                end
                BITGAP: begin
                    if (phase_done) begin
                        led     <= 1'b1;
                        cur_bit <= cur_bit - 1'b1;
                        state   <= ON;
                    end
                end
                CODEGAP: begin
                    if (phase_done) begin
                        cur_bit <= TOP_BIT;
                        if (cur_code != LAST_CODE) begin
                            cur_code <= cur_code + 1'b1;
                            led      <= 1'b1;
                            state    <= ON;
                        end else if (repeat_en) begin
                            cur_code <= '0;
                            led      <= 1'b1;
                            state    <= ON;
                        end else begin
                            cur_code <= '0;
                            led      <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_code_player.sv
// Self-checking bench for led_code_player: LED run lengths and done pulses
// are predicted from the code bits and compared by an independent monitor.
module tb_led_code_player;

    localparam int TD    = 4;
    localparam int CW    = 5;
    localparam int NC    = 4;
    localparam int SHORT = 1;
    localparam int LONG  = 3;
    localparam int BG    = 1;
    localparam int CG    = 3;
    localparam logic [NC*CW-1:0] PLAN = {5'b10111, 5'b10101, 5'b10110, 5'b01011};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             repeat_en = 1'b0;
    logic [NC*CW-1:0] codes = PLAN;
    logic             led;
    logic             busy;
    logic             done;
    logic [1:0]       cur_code;
    logic [2:0]       cur_bit;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          exp_done = 0;
    bit          discard_run = 1'b0;
    int          high_runs = 0;

    led_code_player #(
        .CODE_W    (CW),
        .NUM_CODES (NC),
        .TICK_DIV  (TD),
        .SHORT_U   (SHORT),
        .LONG_U    (LONG),
        .BITGAP_U  (BG),
        .CODEGAP_U (CG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .repeat_en (repeat_en),
        .codes     (codes),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .cur_code  (cur_code),
        .cur_bit   (cur_bit)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one (level, length) entry per LED run of a pass.
    task automatic push_runs(input logic [NC*CW-1:0] c, input int passes);
        logic [CW-1:0] code;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < NC; i++) begin
                code = c[i*CW +: CW];
                for (int b = CW - 1; b >= 0; b--) begin
                    exp_q.push_back({1'b1, 15'((code[b] ? LONG : SHORT) * TD)});
                    exp_q.push_back({1'b0, 15'(((b == 0) ? CG : BG) * TD)});
                end
            end
        end
    endtask

    function automatic int pass_len(input logic [NC*CW-1:0] c);
        int n = 0;
        logic [CW-1:0] code;
        for (int i = 0; i < NC; i++) begin
            code = c[i*CW +: CW];
            for (int b = CW - 1; b >= 0; b--) begin
                n += ((code[b] ? LONG : SHORT) + ((b == 0) ? CG : BG)) * TD;
            end
        end
        return n;
    endfunction

    task automatic close_run(input bit lvl, input int len);
        logic [15:0] e;
        if (lvl) high_runs++;
        if (discard_run) begin
            discard_run = 1'b0;
        end else begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL led_run_extra: got level=%0d len=%0d, expected no run", lvl, len);
            end else begin
                e = exp_q.pop_front();
                if ({lvl, 15'(len)} !== e) begin
                    failures++;
                    $display("FAIL led_run: got level=%0d len=%0d, expected level=%0d len=%0d",
                             lvl, len, e[15], e[14:0]);
                end
            end
        end
    endtask

    // Monitor: measures LED runs while busy and checks done pulses.
    initial begin
        bit led_p = 1'b0;
        bit busy_p = 1'b0;
        bit done_p = 1'b0;
        int run_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                led_p = 1'b0; busy_p = 1'b0; done_p = 1'b0; run_len = 0;
            end else begin
                if (busy_p && (busy !== 1'b1 || led !== led_p)) close_run(led_p, run_len);
                if (busy === 1'b1) run_len = (busy_p && led === led_p) ? run_len + 1 : 1;
                else run_len = 0;
                if (done === 1'b1) begin
                    if (done_p) begin
                        chk("done_one_cycle", 32'(done_p), 0);
                    end else begin
                        chk("done_on_busy_fall", 32'({busy_p, busy}), 2);
                        chk("done_expected", 32'(exp_done > 0), 1);
                        if (exp_done > 0) exp_done--;
                    end
                end
                led_p = led; busy_p = busy; done_p = done;
            end
        end
    end

    // driver tasks
    task automatic start_seq(input logic [NC*CW-1:0] c, input int passes, input bit want_done);
        push_runs(c, passes);
        if (want_done) exp_done++;
        @(posedge clk); #2;
        codes = c;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("start_led", 32'(led), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_code", 32'(cur_code), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < budget);
        chk("seq_finished", 32'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_led(input bit level, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led !== level && n < budget);
        chk("led_reached", 32'(led), 32'(level));
    endtask

    task automatic wait_code(input int idx, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cur_code !== 2'(idx) && n < budget);
        chk("code_reached", 32'(cur_code), 32'(idx));
    endtask

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic [NC*CW-1:0] c;
        int L;
        int hr0;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_code", 32'(cur_code), 0);
        chk("rst_bit", 32'(cur_bit), CW - 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_led", 32'(led), 0);
        end
        chk("idle_bit", 32'(cur_bit), CW - 1);
        chk("idle_done", 32'(done), 0);

        // plan codes, single pass, with ignored start pulses and code changes
        hr0 = high_runs;
        start_seq(PLAN, 1, 1'b1);
        codes = 20'($urandom);
        repeat (71) @(posedge clk);
        @(negedge clk);
        chk("code0_last_cycle", 32'(cur_code), 0);
        @(posedge clk);
        @(negedge clk);
        chk("code1_first_cycle", 32'(cur_code), 1);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 40)) @(posedge clk);
            #2;
            start = 1'b1;
            codes = 20'($urandom);
            @(posedge clk); #2;
            start = 1'b0;
        end
        wait_idle(2000);
        chk("high_run_count", 32'(high_runs - hr0), NC * CW);

        // random codes, including an all-zero and an all-one code
        for (int r = 0; r < 3; r++) begin
            c = 20'($urandom);
            if (r == 0) c[CW-1:0] = '0;
            if (r == 1) c[NC*CW-1 -: CW] = '1;
            start_seq(c, 1, 1'b1);
            codes = 20'($urandom);
            wait_idle(2000);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // repeat mode: loop once, then drop repeat_en
        L = pass_len(PLAN);
        repeat_en = 1'b1;
        start_seq(PLAN, 2, 1'b1);
        repeat (L - 1) @(posedge clk);
        @(negedge clk);
        chk("rep_last_code", 32'(cur_code), NC - 1);
        chk("rep_last_led", 32'(led), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rep_wrap_code", 32'(cur_code), 0);
        chk("rep_wrap_led", 32'(led), 1);
        chk("rep_wrap_busy", 32'(busy), 1);
        repeat (L / 2) @(posedge clk);
        #2;
        repeat_en = 1'b0;
        wait_idle(3000);

        // abort inside the long flash of bit 3 of code 0
        start_seq(PLAN, 1, 1'b0);
        wait_led(1'b0, 100);
        wait_led(1'b1, 100);
        repeat (5) @(posedge clk);
        #2;
        discard_run = 1'b1;
        exp_q.delete();
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_led", 32'(led), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_code", 32'(cur_code), 0);
        chk("abort_bit", 32'(cur_bit), CW - 1);
        chk("abort_done", 32'(done), 0);
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 0);

        // start and abort together while idle
        @(posedge clk); #2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_led", 32'(led), 0);

        // async reset during a bit gap of code 1, then replay
        start_seq(PLAN, 1, 1'b1);
        wait_code(1, 200);
        wait_led(1'b0, 100);
        wait_led(1'b1, 100);
        wait_led(1'b0, 100);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_done = 0;
        #1;
        chk("arst_led", 32'(led), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_code", 32'(cur_code), 0);
        chk("arst_bit", 32'(cur_bit), CW - 1);
        chk("arst_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        start_seq(PLAN, 1, 1'b1);
        wait_idle(2000);

        chk("runs_left", 32'(exp_q.size()), 0);
        chk("done_left", 32'(exp_done), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
